// File: rtl/muldiv32_pkg.sv
// ============================================================================
// muldiv_pkg : shared encodings for the muldiv32 iterative multiply/divide unit
// Rev 1.0
// ============================================================================
`default_nettype none

package muldiv_pkg;

  typedef logic [1:0] md_op_t;
  typedef logic [1:0] state_t;

  localparam md_op_t MD_MULT  = 2'b00;
  localparam md_op_t MD_MULTU = 2'b01;
  localparam md_op_t MD_DIV   = 2'b10;
  localparam md_op_t MD_DIVU  = 2'b11;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_FIX  = 2'd2;

  localparam logic [3:0] ALU_CTRL_MULT  = 4'b1100;
  localparam logic [3:0] ALU_CTRL_MULTU = 4'b1101;
  localparam logic [3:0] ALU_CTRL_DIV   = 4'b1110;
  localparam logic [3:0] ALU_CTRL_DIVU  = 4'b1111;

  function automatic md_op_t md_op_from_alu(input logic [3:0] alu_ctrl);
    md_op_t op;
    op = MD_MULTU;
    case (alu_ctrl)
      ALU_CTRL_MULT:  op = MD_MULT;
      ALU_CTRL_MULTU: op = MD_MULTU;
      ALU_CTRL_DIV:   op = MD_DIV;
      ALU_CTRL_DIVU:  op = MD_DIVU;
      default:        op = MD_MULTU;
    endcase
    return op;
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv32_if.sv
// ============================================================================
// muldiv32_if : start/busy/done handshake and HI/LO access for muldiv32
// Rev 1.0
// ============================================================================
`default_nettype none

interface muldiv32_if #(parameter int W = 32);
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         hi_we;
  logic         lo_we;
  logic [W-1:0] wdata;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface

`default_nettype wire

// File: rtl/muldiv32_adder.sv
// ============================================================================
// adder : W-bit ripple adder with carry in/out, shared by the execute stage
// Rev 1.0
// ============================================================================
`default_nettype none

module adder #(
  parameter int W = 32
) (
  input  wire logic [W-1:0] a,
  input  wire logic [W-1:0] b,
  input  wire logic         c_in,
  output logic      [W-1:0] sum,
  output logic              c_out
);

  assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c_in};

endmodule

`default_nettype wire

// File: rtl/muldiv32.sv
// ============================================================================
// muldiv32 : iterative 32-bit MULT/MULTU/DIV/DIVU producing the HI/LO pair
// Rev 1.0
// ============================================================================
`default_nettype none

module muldiv32
  import muldiv_pkg::*;
#(
  parameter int W = 32
) (
  input  wire logic  clk,
  input  wire logic  rst_n,
  muldiv32_if.slave  bus
);

  localparam int CNT_W = $clog2(W + 1);

  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_op;
  logic [W-1:0]     r_acc_hi, r_acc_lo, r_opnd;
  logic [W-1:0]     r_hi, r_lo;
  logic             r_neg_lo, r_neg_hi, r_div_zero, r_done;

  logic             w_in_signed, w_in_div;
  logic [W-1:0]     w_a_mag, w_b_mag;
  logic             w_is_div;
  logic [W-1:0]     w_rem_shift, w_add_a, w_add_b, w_sum;
  logic             w_add_cin, w_cout, w_fits;
  logic [W:0]       w_mul_hi_full;
  logic [2*W-1:0]   w_prod, w_prod_fix;
  logic [W-1:0]     w_quo_fix, w_rem_fix;

  assign w_in_signed = ~bus.op[0];
  assign w_in_div    = bus.op[1];
  assign w_a_mag     = (w_in_signed && bus.a[W-1]) ? -bus.a : bus.a;
  assign w_b_mag     = (w_in_signed && bus.b[W-1]) ? -bus.b : bus.b;

  // One shared adder: add multiplicand for MUL, subtract divisor for DIV
  assign w_is_div    = r_op[1];
  assign w_rem_shift = {r_acc_hi[W-2:0], r_acc_lo[W-1]};
  assign w_add_a     = w_is_div ? w_rem_shift : r_acc_hi;
  assign w_add_b     = w_is_div ? ~r_opnd     : r_opnd;
  assign w_add_cin   = w_is_div;

  adder #(.W(W)) u_adder (
    .a     (w_add_a),
    .b     (w_add_b),
    .c_in  (w_add_cin),
    .sum   (w_sum),
    .c_out (w_cout)
  );

  assign w_mul_hi_full = r_acc_lo[0] ? {w_cout, w_sum} : {1'b0, r_acc_hi};
  // The bit shifted out of rem makes the trial value exceed any W-bit divisor
  assign w_fits        = r_acc_hi[W-1] | w_cout;

  assign w_prod     = {r_acc_hi, r_acc_lo};
  assign w_prod_fix = r_neg_lo ? -w_prod : w_prod;
  assign w_quo_fix  = r_div_zero ? {W{1'b1}} : (r_neg_lo ? -r_acc_lo : r_acc_lo);
  assign w_rem_fix  = r_neg_hi ? -r_acc_hi : r_acc_hi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.start) w_state_next = ST_RUN;
      ST_RUN:  if (r_cnt == CNT_W'(1)) w_state_next = ST_FIX;
      ST_FIX:  w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (r_state != ST_IDLE);
    bus.done = r_done;
    bus.hi   = r_hi;
    bus.lo   = r_lo;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_op       <= MD_MULT;
      r_acc_hi   <= '0;
      r_acc_lo   <= '0;
      r_opnd     <= '0;
      r_neg_lo   <= 1'b0;
      r_neg_hi   <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (bus.start) begin
          r_op       <= bus.op;
          r_cnt      <= CNT_W'(W);
          r_acc_hi   <= '0;
          r_acc_lo   <= w_in_div ? w_a_mag : w_b_mag;
          r_opnd     <= w_in_div ? w_b_mag : w_a_mag;
          r_neg_lo   <= w_in_signed & (bus.a[W-1] ^ bus.b[W-1]);
          r_neg_hi   <= (bus.op == MD_DIV) & bus.a[W-1];
          r_div_zero <= (bus.b == '0);
        end
        ST_RUN: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_is_div) begin
            r_acc_hi <= w_fits ? w_sum : w_rem_shift;
            r_acc_lo <= {r_acc_lo[W-2:0], w_fits};
          end else begin
            r_acc_hi <= w_mul_hi_full[W:1];
            r_acc_lo <= {w_mul_hi_full[0], r_acc_lo[W-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == ST_FIX);
      if (r_state == ST_IDLE) begin
        if (bus.hi_we) r_hi <= bus.wdata;
        if (bus.lo_we) r_lo <= bus.wdata;
      end else if (r_state == ST_FIX) begin
        r_hi <= w_is_div ? w_rem_fix : w_prod_fix[2*W-1:W];
        r_lo <= w_is_div ? w_quo_fix : w_prod_fix[W-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_muldiv32.sv
// ============================================================================
// tb_muldiv32 : scoreboard bench for muldiv32 (results, latency, handshake)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_muldiv32;

  localparam int W = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv32_if #(.W(W)) bus();

  muldiv32 #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           s_cyc;
    string        tag;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] cur_hi = '0;
  logic [W-1:0] cur_lo = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb2, q, m;
    logic [63:0] r;
    sa  = longint'($signed(a));
    sb2 = longint'($signed(b));
    r   = '0;
    case (op)
      2'b00: r = 64'(sa * sb2);
      2'b01: r = {32'd0, a} * {32'd0, b};
      2'b10: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb2;
          m = sa % sb2;
          r = {m[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else            r = {a % b, a / b};
      end
    endcase
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check({e.tag, "_hi"},   64'(bus.hi), 64'(e.hi));
        check({e.tag, "_lo"},   64'(bus.lo), 64'(e.lo));
        check({e.tag, "_lat"},  64'(cyc - e.s_cyc), 64'd33);
        check({e.tag, "_busy"}, 64'(bus.busy), 64'd0);
        cur_hi = e.hi;
        cur_lo = e.lo;
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
    int n;
    logic [63:0] m;
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) check({tag, "_idle_timeout"}, 64'd1, 64'd0);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    m = model(op, a, b);
    @(posedge clk); #1;
    sb.push_back('{hi: m[63:32], lo: m[31:0], s_cyc: cyc, tag: tag});
    bus.start = 1'b0;
    bus.op    = 2'($urandom);
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int busy_n;
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_hi",   64'(bus.hi),   64'd0);
    check("rst_lo",   64'(bus.lo),   64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    busy_n = 0;
    while (bus.busy === 1'b1 && busy_n < 100) begin
      if (busy_n == 5) check("hold_hi_run", 64'(bus.hi), 64'd0);
      busy_n++;
      @(posedge clk); #1;
    end
    check("busy_cycles", 64'(busy_n), 64'd33);
    drain();

    issue(2'b00, 32'hFFFF_FFFE, 32'h0000_0003, "mult_neg");
    issue(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, "div_neg");
    issue(2'b11, 32'd100,       32'd0,         "divu_zero");
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    issue(2'b10, 32'hFFFF_FF9C, 32'd0,         "div_zero_neg");
    issue(2'b00, 32'h8000_0000, 32'h8000_0000, "mult_minmin");
    for (int i = 0; i < 6; i++) begin
      issue(2'(i), $urandom, (i == 5) ? 32'd0 : $urandom_range(1, 32'hFFFF), "rand");
    end

    // Wait for a done cycle and confirm the next start lands on it
    issue(2'b01, 32'd12, 32'd13, "b2b_a");
    busy_n = 0;
    while (bus.busy === 1'b1 && busy_n < 100) begin
      @(posedge clk); #1;
      busy_n++;
    end
    check("b2b_done_same_cycle", 64'(bus.done), 64'd1);
    issue(2'b11, 32'd1000, 32'd7, "b2b_b");
    drain();

    issue(2'b01, 32'd1000, 32'd1000, "ignore_start");
    repeat (9) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'd5; bus.b = 32'd5;
    bus.hi_we = 1'b1; bus.wdata = 32'h0000_1234;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.hi_we = 1'b0;
    check("hi_we_busy", 64'(bus.hi), 64'(cur_hi));
    check("busy_after_ignored", 64'(bus.busy), 64'd1);
    drain();

    bus.hi_we = 1'b1; bus.wdata = 32'hCAFE_0001;
    @(posedge clk); #1;
    bus.hi_we = 1'b0;
    check("mthi_idle", 64'(bus.hi), 64'h0000_0000_CAFE_0001);
    bus.lo_we = 1'b1; bus.wdata = 32'hBEEF_0002;
    @(posedge clk); #1;
    bus.lo_we = 1'b0;
    check("mtlo_idle", 64'(bus.lo), 64'h0000_0000_BEEF_0002);

    bus.hi_we = 1'b1; bus.wdata = 32'h5555_AAAA;
    issue(2'b01, 32'd3, 32'd4, "we_with_start");
    bus.hi_we = 1'b0;
    check("we_with_start_hi", 64'(bus.hi), 64'h0000_0000_5555_AAAA);
    drain();

    issue(2'b11, 32'd12345, 32'd7, "rst_mid");
    repeat (14) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_done", 64'(bus.done), 64'd0);
    check("midrst_hi",   64'(bus.hi),   64'd0);
    check("midrst_lo",   64'(bus.lo),   64'd0);
    sb.delete();
    cur_hi = '0;
    cur_lo = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("no_done_after_rst", 64'(bus.busy), 64'd0);
    issue(2'b01, 32'd6, 32'd7, "post_rst");
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
